mem_arbiter: RTL and testbench

Two-port round-robin arbiter for the single-ported unified `mem` (combinational read, write on rising `clk` when `we`) in the multicycle processor. It shares that one memory between an instruction-fetch requester (port 0) and a load/store requester (port 1), issuing at most one access per cycle. It returns read data one cycle later and rejects misaligned word addresses without touching memory.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter_rr_arb2.sv | 44 ++++
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared constants and helpers for the unified-memory arbiter.
//   PORT_IF / PORT_DS : port identifiers (instruction fetch, load/store)
//   ALIGN_MASK        : byte-offset bits that must be zero for a word access
//   last_t            : encoding of the round-robin "last granted" state
package mem_arb_pkg;

    localparam logic       PORT_IF    = 1'b0;
    localparam logic       PORT_DS    = 1'b1;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic {
        LAST_IF = 1'b0,
        LAST_DS = 1'b1
    } last_t;

    // True when the low address bits select a non-word-aligned byte.
    function automatic logic misaligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of requester-side and memory-side signals around
// mem_arbiter.
//   pX_req/we/addr/wdata : request from port X (held until pX_gnt)
//   pX_gnt               : combinational accept
//   pX_rvalid/rdata/err  : registered response, one cycle after the grant
//   mem_we/mem_a/mem_wd  : drive the single-ported memory
//   mem_rd               : combinational read data from the memory
// Modports: slave = arbiter view, master = requesters + memory view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;
    logic          p0_err;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;
    logic          p1_err;

    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rd,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_we, mem_a, mem_wd
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rd,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, reset : clock and synchronous active-high reset
//   req[1:0]   : request per port
//   gnt[1:0]   : combinational grant, one-hot or zero
// On a tie the port that was not granted most recently wins. Reset leaves
// "last" at port 1 so port 0 wins the first tie. No grants while in reset.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    last_t last, last_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= LAST_DS;
        end else begin
            last <= last_nxt;
        end
    end

    always_comb begin
        gnt      = 2'b00;
        last_nxt = last;
        if (!reset) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last == LAST_DS) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
            if (gnt[0]) begin
                last_nxt = LAST_IF;
            end else if (gnt[1]) begin
                last_nxt = LAST_DS;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch
// (port 0) and load/store (port 1), at most one access per cycle.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mem_arbiter_if.slave (requests, responses, memory side)
// The granted port's payload is steered to the memory in the same cycle;
// the response (read data or error) is registered and presented on the
// granted port one cycle later. Misaligned accesses are consumed but never
// write memory and respond with err=1, rdata=0.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);

    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          granted;
    logic          sel_port;
    logic          sel_we;
    logic          sel_mis;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          rsp_valid;
    logic          rsp_port;
    logic          rsp_err;
    logic [DW-1:0] rsp_data;

    assign req = {bus.p1_req, bus.p0_req};

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt)
    );

    assign granted  = |gnt;
    assign sel_port = gnt[1] ? PORT_DS : PORT_IF;

    // Payload mux; everything reads as zero when nothing is granted.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt[0]) begin
            sel_we    = bus.p0_we;
            sel_addr  = bus.p0_addr;
            sel_wdata = bus.p0_wdata;
        end else if (gnt[1]) begin
            sel_we    = bus.p1_we;
            sel_addr  = bus.p1_addr;
            sel_wdata = bus.p1_wdata;
        end
    end

    assign sel_mis    = granted && misaligned(sel_addr[1:0]);

    assign bus.mem_a  = sel_addr;
    assign bus.mem_wd = sel_wdata;
    assign bus.mem_we = sel_we && !sel_mis;

    // Response stage: only the valid flag needs reset; port/err/data are
    // masked by it on the way out.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= granted;
        end
    end

    always_ff @(posedge clk) begin
        rsp_port <= sel_port;
        rsp_err  <= sel_mis;
        rsp_data <= (granted && !sel_we && !sel_mis) ? bus.mem_rd : '0;
    end

    assign bus.p0_gnt    = gnt[0];
    assign bus.p1_gnt    = gnt[1];

    assign bus.p0_rvalid = rsp_valid && (rsp_port == PORT_IF);
    assign bus.p1_rvalid = rsp_valid && (rsp_port == PORT_DS);

    assign bus.p0_rdata  = bus.p0_rvalid ? rsp_data : '0;
    assign bus.p1_rdata  = bus.p1_rvalid ? rsp_data : '0;
    assign bus.p0_err    = bus.p0_rvalid && rsp_err;
    assign bus.p1_err    = bus.p1_rvalid && rsp_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural
// memory and a transaction-level reference model.
module tb_mem_arbiter;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic mem_load = 1'b1;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural single-ported memory: combinational read, clocked write.
    logic [31:0] mem [0:255];

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] v;
        v = 32'(i);
        return (i == 10) ? 32'h0000_00AA : (32'hC0DE_0000 | v);
    endfunction

    assign bus.mem_rd = mem[bus.mem_a[9:2]];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_a[9:2]] <= bus.mem_wd;
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    logic [31:0] ref_mem [0:255];
    int          m_last = 1;          // port served most recently
    int          n_last;
    logic [1:0]  e_gnt;
    logic        e_we;
    logic [31:0] e_a, e_wd;
    logic [1:0]  n_rv, n_err, e_rv, e_err;
    logic [31:0] n_rd0, n_rd1, e_rd0, e_rd1;

    // Decide the expected grant and next response from the request rules.
    task automatic model_comb();
        logic [31:0] a, d;
        logic        w, mis;
        int          g;
        g = -1;
        if (!reset) begin
            if (bus.p0_req && bus.p1_req) g = (m_last == 0) ? 1 : 0;
            else if (bus.p0_req)          g = 0;
            else if (bus.p1_req)          g = 1;
        end
        e_gnt = 2'b00; e_we = 1'b0; e_a = '0; e_wd = '0;
        n_rv  = 2'b00; n_err = 2'b00; n_rd0 = '0; n_rd1 = '0;
        n_last = reset ? 1 : m_last;
        if (g >= 0) begin
            a   = (g == 1) ? bus.p1_addr  : bus.p0_addr;
            d   = (g == 1) ? bus.p1_wdata : bus.p0_wdata;
            w   = (g == 1) ? bus.p1_we    : bus.p0_we;
            mis = (a % 4) != 0;
            e_gnt[g] = 1'b1;
            e_a      = a;
            e_wd     = d;
            e_we     = w && !mis;
            n_rv[g]  = 1'b1;
            n_err[g] = mis;
            if (!w && !mis) begin
                if (g == 0) n_rd0 = ref_mem[a[9:2]];
                else        n_rd1 = ref_mem[a[9:2]];
            end
            n_last = g;
        end
    endtask

    task automatic model_commit();
        if (e_we) ref_mem[e_a[9:2]] = e_wd;
        m_last = n_last;
        e_rv   = n_rv;
        e_err  = n_err;
        e_rd0  = n_rd0;
        e_rd1  = n_rd1;
    endtask

    task automatic drive(input int port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (port == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b1, 1'b1, 32'd40, 32'hDEAD_BEEF);
        drive(1, 1'b1, 1'b0, 32'd100, 32'h0);
        #1; model_comb();
        tests_run++;
        if ({bus.p1_gnt, bus.p0_gnt} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_gnt got %b want 00", {bus.p1_gnt, bus.p0_gnt});
        end
        tests_run++;
        if (bus.mem_we !== 1'b0 || bus.mem_a !== 32'h0 || bus.mem_wd !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_memside got we=%b a=%h wd=%h want 0/0/0", bus.mem_we, bus.mem_a, bus.mem_wd);
        end
        @(posedge clk); #1; model_commit();
        tests_run++;
        if ({bus.p1_rvalid, bus.p1_err, bus.p0_rvalid, bus.p0_err} !== 4'b0000 ||
            bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rsp got rv/err=%b rd0=%h rd1=%h want all 0",
                     {bus.p1_rvalid, bus.p1_err, bus.p0_rvalid, bus.p0_err}, bus.p0_rdata, bus.p1_rdata);
        end
        @(negedge clk);
        reset = 1'b0; mem_load = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1; model_comb();
        @(posedge clk); #1; model_commit();
    endtask

    task automatic test_single_read();
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'd40, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1; model_comb();
        tests_run++;
        if ({bus.p1_gnt, bus.p0_gnt} !== 2'b01 || e_gnt !== 2'b01) begin
            tests_failed++; $display("FAIL single_gnt got %b want 01", {bus.p1_gnt, bus.p0_gnt});
        end
        tests_run++;
        if (bus.mem_a !== 32'd40 || bus.mem_we !== 1'b0) begin
            tests_failed++; $display("FAIL single_mem got a=%0d we=%b want 40/0", bus.mem_a, bus.mem_we);
        end
        @(posedge clk); #1; model_commit();
        tests_run++;
        if (bus.p0_rvalid !== 1'b1 || bus.p0_err !== 1'b0 || bus.p1_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_rsp got rv0=%b err0=%b rv1=%b want 1/0/0", bus.p0_rvalid, bus.p0_err, bus.p1_rvalid);
        end
        tests_run++;
        if (bus.p0_rdata !== 32'h0000_00AA) begin
            tests_failed++; $display("FAIL single_rdata got %h want 000000aa", bus.p0_rdata);
        end
    endtask

    task automatic test_write_readback();
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b1, 32'd100, 32'hABCD_1234);
        #1; model_comb();
        tests_run++;
        if ({bus.p1_gnt, bus.p0_gnt} !== 2'b10) begin
            tests_failed++; $display("FAIL wr_gnt got %b want 10", {bus.p1_gnt, bus.p0_gnt});
        end
        tests_run++;
        if (bus.mem_we !== 1'b1 || bus.mem_a !== 32'd100 || bus.mem_wd !== 32'hABCD_1234) begin
            tests_failed++;
            $display("FAIL wr_mem got we=%b a=%0d wd=%h want 1/100/abcd1234", bus.mem_we, bus.mem_a, bus.mem_wd);
        end
        @(posedge clk); #1; model_commit();
        tests_run++;
        if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== 32'h0 || bus.p1_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_rsp got rv=%b rd=%h err=%b want 1/0/0", bus.p1_rvalid, bus.p1_rdata, bus.p1_err);
        end
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'd100, 32'h0);
        #1; model_comb();
        tests_run++;
        if (bus.mem_we !== 1'b0 || bus.p1_gnt !== 1'b1) begin
            tests_failed++; $display("FAIL rb_mem got we=%b gnt1=%b want 0/1", bus.mem_we, bus.p1_gnt);
        end
        @(posedge clk); #1; model_commit();
        tests_run++;
        if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== 32'hABCD_1234) begin
            tests_failed++;
            $display("FAIL rb_rdata got rv=%b rd=%h want 1/abcd1234", bus.p1_rvalid, bus.p1_rdata);
        end
    endtask

    task automatic test_contention();
        int order [4] = '{0, 1, 0, 1};
        logic [1:0] want;
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1; model_comb();
        @(posedge clk); #1; model_commit();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            reset = 1'b0;
            drive(0, 1'b1, 1'b0, 32'd40, 32'h0);
            drive(1, 1'b1, 1'b0, 32'd100, 32'h0);
            #1; model_comb();
            want = 2'b01 << order[i];
            tests_run++;
            if ({bus.p1_gnt, bus.p0_gnt} !== want || e_gnt !== want) begin
                tests_failed++;
                $display("FAIL cont_gnt[%0d] got %b want %b", i, {bus.p1_gnt, bus.p0_gnt}, want);
            end
            @(posedge clk); #1; model_commit();
            tests_run++;
            if ({bus.p1_rvalid, bus.p0_rvalid} !== want) begin
                tests_failed++;
                $display("FAIL cont_rvalid[%0d] got %b want %b", i, {bus.p1_rvalid, bus.p0_rvalid}, want);
            end
            tests_run++;
            if ((order[i] == 0 && bus.p0_rdata !== 32'h0000_00AA) ||
                (order[i] == 1 && bus.p1_rdata !== 32'hABCD_1234)) begin
                tests_failed++;
                $display("FAIL cont_rdata[%0d] got rd0=%h rd1=%h", i, bus.p0_rdata, bus.p1_rdata);
            end
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b1, 32'd102, 32'h5555_5555);
        #1; model_comb();
        tests_run++;
        if (bus.p1_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin
            tests_failed++; $display("FAIL mis_gnt got gnt1=%b we=%b want 1/0", bus.p1_gnt, bus.mem_we);
        end
        @(posedge clk); #1; model_commit();
        tests_run++;
        if (bus.p1_rvalid !== 1'b1 || bus.p1_err !== 1'b1 || bus.p1_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL mis_rsp got rv=%b err=%b rd=%h want 1/1/0", bus.p1_rvalid, bus.p1_err, bus.p1_rdata);
        end
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'd100, 32'h0);
        #1; model_comb();
        @(posedge clk); #1; model_commit();
        tests_run++;
        if (bus.p1_rdata !== 32'hABCD_1234 || bus.p1_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mis_unchanged got rd=%h err=%b want abcd1234/0", bus.p1_rdata, bus.p1_err);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'd40, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1; model_comb();
        @(posedge clk); #1; model_commit();
        tests_run++;
        if (bus.p0_rvalid !== 1'b1) begin
            tests_failed++; $display("FAIL rmid_pre got rv0=%b want 1", bus.p0_rvalid);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 32'd40, 32'h0);
        drive(1, 1'b1, 1'b1, 32'd104, 32'h0000_0077);
        #1; model_comb();
        tests_run++;
        if ({bus.p1_gnt, bus.p0_gnt} !== 2'b00 || bus.mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_gnt got gnt=%b we=%b want 00/0", {bus.p1_gnt, bus.p0_gnt}, bus.mem_we);
        end
        @(posedge clk); #1; model_commit();
        tests_run++;
        if ({bus.p1_rvalid, bus.p0_rvalid} !== 2'b00) begin
            tests_failed++; $display("FAIL rmid_rvalid got %b want 00", {bus.p1_rvalid, bus.p0_rvalid});
        end
        @(negedge clk);
        reset = 1'b0;
        #1; model_comb();
        tests_run++;
        if ({bus.p1_gnt, bus.p0_gnt} !== 2'b01) begin
            tests_failed++; $display("FAIL rmid_tie got %b want 01", {bus.p1_gnt, bus.p0_gnt});
        end
        @(posedge clk); #1; model_commit();
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1; model_comb();
        tests_run++;
        if (bus.p1_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_a !== 32'd104) begin
            tests_failed++;
            $display("FAIL rmid_reissue got gnt1=%b we=%b a=%0d want 1/1/104", bus.p1_gnt, bus.mem_we, bus.mem_a);
        end
        @(posedge clk); #1; model_commit();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
            drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
            #1; model_comb();
            tests_run++;
            if (bus.mem_we !== 1'b0 || bus.mem_a !== 32'h0 || {bus.p1_gnt, bus.p0_gnt} !== 2'b00) begin
                tests_failed++;
                $display("FAIL idle_mem[%0d] got we=%b a=%h gnt=%b want 0/0/00", i, bus.mem_we, bus.mem_a,
                         {bus.p1_gnt, bus.p0_gnt});
            end
            @(posedge clk); #1; model_commit();
            tests_run++;
            if ({bus.p1_rvalid, bus.p0_rvalid} !== 2'b00) begin
                tests_failed++; $display("FAIL idle_rvalid[%0d] got %b want 00", i, {bus.p1_rvalid, bus.p0_rvalid});
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  pend = 2'b00;
        logic [31:0] addr;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        addr = 32'($urandom_range(0, 15)) * 4;
                        if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
                        drive(p, 1'b1, 1'($urandom_range(0, 1)), addr, $urandom);
                        pend[p] = 1'b1;
                    end else begin
                        drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
                    end
                end
            end
            #1; model_comb();
            tests_run++;
            if ({bus.p1_gnt, bus.p0_gnt} !== e_gnt) begin
                tests_failed++; $display("FAIL rand_gnt[%0d] got %b want %b", c, {bus.p1_gnt, bus.p0_gnt}, e_gnt);
            end
            tests_run++;
            if (bus.mem_we !== e_we || bus.mem_a !== e_a || bus.mem_wd !== e_wd) begin
                tests_failed++;
                $display("FAIL rand_mem[%0d] got we=%b a=%h wd=%h want %b/%h/%h", c, bus.mem_we, bus.mem_a,
                         bus.mem_wd, e_we, e_a, e_wd);
            end
            @(posedge clk); #1; model_commit();
            pend = pend & ~e_gnt;
            tests_run++;
            if ({bus.p1_rvalid, bus.p0_rvalid} !== e_rv || {bus.p1_err, bus.p0_err} !== e_err) begin
                tests_failed++;
                $display("FAIL rand_rsp[%0d] got rv=%b err=%b want %b/%b", c, {bus.p1_rvalid, bus.p0_rvalid},
                         {bus.p1_err, bus.p0_err}, e_rv, e_err);
            end
            tests_run++;
            if (bus.p0_rdata !== e_rd0 || bus.p1_rdata !== e_rd1) begin
                tests_failed++;
                $display("FAIL rand_rdata[%0d] got %h/%h want %h/%h", c, bus.p0_rdata, bus.p1_rdata, e_rd0, e_rd1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_single_read();
        test_write_readback();
        test_contention();
        test_misaligned();
        test_reset_mid();
        test_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
